serial_bit_feeder: RTL and testbench

Parallel-to-serial front end that drives the 1-bit input of the Moore "101" overlapping sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding register allows back-to-back words to stream with no idle bit between them. Between words the serial line parks at a fixed idle level.

---
 rtl/feeder_pkg.sv | 10 +
 rtl/piso_shift_reg.sv | 21 ++
 rtl/serial_bit_feeder.sv | 62 ++++++
 tb/tb_serial_bit_feeder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state encoding and helpers for the serial bit feeder
package feeder_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
  function automatic logic out_bit(input logic msb, input logic lsb, input bit msb_first);
    return msb_first ? msb : lsb;
  endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable shift register presenting its leading bit in either direction
module piso_shift_reg
  import feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else if (load) sr <= d;
    else if (shift) sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  assign q = out_bit(sr[WIDTH-1], sr[0], MSB_FIRST);
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: valid/ready word intake with one-word hold, serialised one bit per clock
module serial_bit_feeder
  import feeder_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter bit   MSB_FIRST = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hold, load_d;
  logic hold_full, xfer, last, load, shift, q;
  assign din_ready = !hold_full && !reset;
  assign xfer = din_valid && din_ready;
  assign last = state == SHIFT && cnt == CNT_W'(WIDTH - 1);
  always_comb begin
    load = (state == IDLE && xfer) || (last && (hold_full || xfer));
    load_d = (last && hold_full) ? hold : din;
    shift = state == SHIFT && !load;
    state_nx = state == IDLE ? (xfer ? SHIFT : IDLE)
             : ((last && !hold_full && !xfer) ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      words_sent <= '0;
    end else begin
      state <= state_nx;
      cnt <= load ? '0 : (state == SHIFT ? cnt + 1'b1 : cnt);
      if (last) words_sent <= words_sent + 16'd1;
      // a word arriving on the last-bit edge with an empty hold bypasses it
      if (state == SHIFT && xfer && !last) begin
        hold <= din;
        hold_full <= 1'b1;
      end else if (last && hold_full) hold_full <= 1'b0;
    end
  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk(clk),
    .reset(reset),
    .load(load),
    .shift(shift),
    .d(load_d),
    .q(q)
  );
  assign ser_out = state == SHIFT ? q : IDLE_BIT;
  assign ser_valid = state == SHIFT;
  assign busy = state == SHIFT || hold_full;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed checks of serialisation, hold overlap, reset and 101 detection
module tb_serial_bit_feeder;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] din0 = '0, din1 = '0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic rdy0, so0, sv0, busy0, rdy1, so1, sv1, busy1;
  logic [15:0] ws0, ws1;
  logic [2:0] hist;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .ser_out(so0), .ser_valid(sv0), .busy(busy0), .words_sent(ws0)
  );
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .ser_out(so1), .ser_valid(sv1), .busy(busy1), .words_sent(ws1)
  );
  // reference Moore "101" overlapping detector fed by u0's serial line
  always @(posedge clk or posedge reset)
    if (reset) hist <= '0;
    else hist <= {hist[1:0], so0};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] w;
    logic [15:0] s2;
    logic [23:0] s3;
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ser_out", so0, 0);
    check("rst_ser_valid", sv0, 0);
    check("rst_busy", busy0, 0);
    check("rst_words", ws0, 0);
    check("rst_ready", rdy0, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", rdy0, 1);
    w = 8'hA5;
    din0 = w; v0 = 1'b1;
    tick;
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("a5_bit", so0, w[7-i]);
      check("a5_valid", sv0, 1);
      tick;
    end
    check("a5_end_valid", sv0, 0);
    check("a5_end_idle", so0, 0);
    check("a5_words", ws0, 1);
    check("a5_busy", busy0, 0);
    s2 = 16'hA55A;
    din0 = 8'hA5; v0 = 1'b1;
    tick;
    din0 = 8'h5A;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        v0 = 1'b0;
        check("b2b_ready_low", rdy0, 0);
      end
      if (k == 8) check("b2b_ready_back", rdy0, 1);
      check("b2b_bit", so0, s2[15-k]);
      check("b2b_valid", sv0, 1);
      tick;
    end
    check("b2b_end_valid", sv0, 0);
    check("b2b_words", ws0, 3);
    s3 = 24'hA55AC3;
    din0 = 8'hA5; v0 = 1'b1;
    tick;
    din0 = 8'h5A;
    for (int k = 0; k < 24; k++) begin
      if (k == 1) din0 = 8'hC3;
      if (k == 4) check("third_blocked", rdy0, 0);
      if (k == 8) begin
        check("third_ready", rdy0, 1);
        check("third_busy", busy0, 1);
      end
      if (k == 9) v0 = 1'b0;
      check("three_bit", so0, s3[23-k]);
      check("three_valid", sv0, 1);
      tick;
    end
    check("three_end_valid", sv0, 0);
    check("three_words", ws0, 6);
    din1 = 8'h01; v1 = 1'b1;
    tick;
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit", so1, (i == 0) ? 1 : 0);
      check("lsb_valid", sv1, 1);
      tick;
    end
    check("lsb_end_valid", sv1, 0);
    check("lsb_words", ws1, 1);
    din0 = 8'hFF; v0 = 1'b1;
    tick;
    din0 = 8'h5A;
    tick;
    v0 = 1'b0;
    repeat (3) tick;
    check("mid_bit4", so0, 1);
    check("mid_busy", busy0, 1);
    #2 reset = 1'b1;
    #1;
    check("async_ser_out", so0, 0);
    check("async_valid", sv0, 0);
    check("async_busy", busy0, 0);
    check("async_words", ws0, 0);
    check("async_ready", rdy0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", rdy0, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (sv0) cnt++;
      tick;
    end
    check("dropped_silent", cnt, 0);
    din0 = 8'hA8; v0 = 1'b1;
    tick;
    v0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (hist == 3'b101) cnt++;
      tick;
    end
    check("det_pulses", cnt, 2);
    check("det_words", ws0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
